// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode definitions: the IF/ID packet type and the fetch queue depth.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Exports: if_id_reg_t (fetch -> decode packet), IF_ID_W (its width),
//          FETCH_QUEUE_DEPTH (default entry count of fetch_queue).
package fetch_queue_pkg;

  localparam int unsigned FETCH_QUEUE_DEPTH = 4;

  // Packet handed from the fetch stage to decode.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] predicted_pc;
    logic        prediction_valid;
    logic        exception_valid;
    logic [4:0]  exception_cause;
  } if_id_reg_t;

  localparam int unsigned IF_ID_W = $bits(if_id_reg_t);

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: DEPTH x WIDTH register array.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; the caller only asserts we when the slot is free.
//
// Ports: clk, we/waddr/wdata (single write port), raddr/rdata (asynchronous read port).
// Contents are not reset; validity is tracked by the controller's occupancy count.
module fq_ram #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupling FIFO between fetch and decode; in-order delivery, flushable.
// Latency: 1 cycle enqueue-to-visible, no same-cycle bypass.
// Backpressure: enq_ready drops when full (unless decode dequeues this cycle) or while a faulting
//               packet is queued; stall_req mirrors !enq_ready.
//
// Ports: clk, rst_n (async active-low), flush; enq_valid/enq_data/enq_ready from fetch;
//        deq_valid/deq_data/deq_ready to decode; count (occupancy 0..DEPTH); stall_req.
// DEPTH must be a power of two and >= 2 so the pointers wrap by natural overflow.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = FETCH_QUEUE_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             enq_valid,
  input  if_id_reg_t       enq_data,
  output logic             enq_ready,
  output logic             deq_valid,
  output if_id_reg_t       deq_data,
  input  logic             deq_ready,
  output logic [PTR_W:0]   count,
  output logic             stall_req
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic             exc_hold_q, exc_hold_d;

  logic             full, empty;
  logic             enq_fire, deq_fire;
  logic             wr_en;
  logic [IF_ID_W-1:0] ram_rdata;
  if_id_reg_t       head;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);

  // A queued faulting packet fences off everything younger; at full, a dequeue in
  // the same cycle frees the slot the new packet lands in.
  assign enq_ready = !exc_hold_q && (!full || deq_ready);
  assign stall_req = !enq_ready;
  assign deq_valid = !empty;

  assign enq_fire = enq_valid && enq_ready;
  assign deq_fire = deq_valid && deq_ready;

  // Flush dominates: nothing is written into the array on a flush cycle.
  assign wr_en = enq_fire && !flush;

  fq_ram #(
    .DEPTH (DEPTH),
    .WIDTH (IF_ID_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (enq_data),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  assign head     = if_id_reg_t'(ram_rdata);
  // Stale array contents are never exposed to decode.
  assign deq_data = empty ? '0 : head;
  assign count    = count_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    exc_hold_d = exc_hold_q;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      exc_hold_d = 1'b0;
    end else begin
      if (enq_fire) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (deq_fire) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      unique case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase

      // Set and clear cannot coincide: while the fence is up nothing enqueues.
      if (enq_fire && enq_data.exception_valid) begin
        exc_hold_d = 1'b1;
      end else if (deq_fire && head.exception_valid) begin
        exc_hold_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      exc_hold_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      exc_hold_q <= exc_hold_d;
    end
  end

  // Structural invariants of the circular buffer.
  a_no_enq_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(enq_fire && full && !deq_ready));

  a_no_deq_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(deq_fire && empty));

  a_count_matches_ptrs : assert property (@(posedge clk) disable iff (!rst_n)
    (count_q <= DEPTH_CNT) &&
    (full ? (wr_ptr_q == rd_ptr_q)
          : (count_q[PTR_W-1:0] == PTR_W'(wr_ptr_q - rd_ptr_q))));

  a_head_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (deq_valid && !deq_ready && !flush) |=> $stable(deq_data));

endmodule
